// File: rtl/ip_tx_arb_pkg.sv
// Shared definitions for the IPv4 transmit arbiter: FSM state encoding and
// the IP header field widths.
package ip_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2
   } arb_state_t;

   localparam int DSCP_W  = 6;
   localparam int ECN_W   = 2;
   localparam int LEN_W   = 16;
   localparam int TTL_W   = 8;
   localparam int PROTO_W = 8;
   localparam int IP_W    = 32;

endpackage

// File: rtl/ip_arb_rr.sv
// Rotating priority encoder: picks the first asserted request at or above
// ptr, wrapping modulo S_COUNT.
module ip_arb_rr
   import ip_tx_arb_pkg::*;
#(
   parameter int S_COUNT = 2,
   parameter int PTR_W   = 1
) (
   input  logic [S_COUNT-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic               any,
   output logic [PTR_W-1:0]   idx
);

   logic [PTR_W-1:0] w_pos;

   always_comb begin
      any   = 1'b0;
      idx   = '0;
      w_pos = '0;
      for (int unsigned k = 0; k < S_COUNT; k++) begin
         w_pos = PTR_W'((32'(ptr) + k) % S_COUNT);
         if (!any && req[w_pos]) begin
            any = 1'b1;
            idx = w_pos;
         end
      end
   end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Per-packet round-robin arbiter sharing one IPv4 transmit port between
// S_COUNT requesters; header is registered, payload is muxed combinationally.
module ip_tx_arbiter
   import ip_tx_arb_pkg::*;
#(
   parameter int S_COUNT = 2,
   parameter int PTR_W   = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [S_COUNT-1:0]         s_ip_hdr_valid,
   output logic [S_COUNT-1:0]         s_ip_hdr_ready,
   input  logic [S_COUNT*DSCP_W-1:0]  s_ip_dscp,
   input  logic [S_COUNT*ECN_W-1:0]   s_ip_ecn,
   input  logic [S_COUNT*LEN_W-1:0]   s_ip_length,
   input  logic [S_COUNT*TTL_W-1:0]   s_ip_ttl,
   input  logic [S_COUNT*PROTO_W-1:0] s_ip_protocol,
   input  logic [S_COUNT*IP_W-1:0]    s_ip_source_ip,
   input  logic [S_COUNT*IP_W-1:0]    s_ip_dest_ip,
   input  logic [S_COUNT*8-1:0]       s_ip_payload_axis_tdata,
   input  logic [S_COUNT-1:0]         s_ip_payload_axis_tvalid,
   output logic [S_COUNT-1:0]         s_ip_payload_axis_tready,
   input  logic [S_COUNT-1:0]         s_ip_payload_axis_tlast,
   input  logic [S_COUNT-1:0]         s_ip_payload_axis_tuser,
   output logic                       m_ip_hdr_valid,
   input  logic                       m_ip_hdr_ready,
   output logic [DSCP_W-1:0]          m_ip_dscp,
   output logic [ECN_W-1:0]           m_ip_ecn,
   output logic [LEN_W-1:0]           m_ip_length,
   output logic [TTL_W-1:0]           m_ip_ttl,
   output logic [PROTO_W-1:0]         m_ip_protocol,
   output logic [IP_W-1:0]            m_ip_source_ip,
   output logic [IP_W-1:0]            m_ip_dest_ip,
   output logic [7:0]                 m_ip_payload_axis_tdata,
   output logic                       m_ip_payload_axis_tvalid,
   input  logic                       m_ip_payload_axis_tready,
   output logic                       m_ip_payload_axis_tlast,
   output logic                       m_ip_payload_axis_tuser,
   output logic [PTR_W-1:0]           grant,
   output logic                       grant_valid,
   output logic                       busy
);

   arb_state_t         r_state, w_state_nxt;
   logic [PTR_W-1:0]   r_grant, r_ptr, w_idx, w_ptr_nxt;
   logic               w_any, w_hdr_fire, w_pkt_end, r_hdr_valid;
   logic [DSCP_W-1:0]  r_dscp;
   logic [ECN_W-1:0]   r_ecn;
   logic [LEN_W-1:0]   r_len;
   logic [TTL_W-1:0]   r_ttl;
   logic [PROTO_W-1:0] r_proto;
   logic [IP_W-1:0]    r_sip, r_dip;

   ip_arb_rr #(.S_COUNT(S_COUNT), .PTR_W(PTR_W)) u_rr (
      .req (s_ip_hdr_valid),
      .ptr (r_ptr),
      .any (w_any),
      .idx (w_idx)
   );

   assign w_hdr_fire = (r_state == ST_IDLE) && w_any;
   assign w_pkt_end  = m_ip_payload_axis_tvalid && m_ip_payload_axis_tready
                       && m_ip_payload_axis_tlast;
   assign w_ptr_nxt  = (r_grant == PTR_W'(S_COUNT - 1)) ? '0 : r_grant + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_any)          w_state_nxt = ST_HDR;
         ST_HDR:     if (m_ip_hdr_ready) w_state_nxt = ST_PAYLOAD;
         ST_PAYLOAD: if (w_pkt_end)      w_state_nxt = ST_IDLE;
         default:                        w_state_nxt = ST_IDLE;
      endcase
   end

   // Only the owner's payload ready is connected, and only once the header is gone.
   always_comb begin
      s_ip_hdr_ready           = '0;
      s_ip_payload_axis_tready = '0;
      m_ip_payload_axis_tvalid = 1'b0;
      if (w_hdr_fire) s_ip_hdr_ready[w_idx] = 1'b1;
      if (r_state == ST_PAYLOAD) begin
         s_ip_payload_axis_tready[r_grant] = m_ip_payload_axis_tready;
         m_ip_payload_axis_tvalid          = s_ip_payload_axis_tvalid[r_grant];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant     <= '0;
         r_ptr       <= '0;
         r_hdr_valid <= 1'b0;
         r_dscp      <= '0;
         r_ecn       <= '0;
         r_len       <= '0;
         r_ttl       <= '0;
         r_proto     <= '0;
         r_sip       <= '0;
         r_dip       <= '0;
      end else begin
         if (w_hdr_fire) begin
            r_grant     <= w_idx;
            r_hdr_valid <= 1'b1;
            r_dscp      <= s_ip_dscp[w_idx*DSCP_W +: DSCP_W];
            r_ecn       <= s_ip_ecn[w_idx*ECN_W +: ECN_W];
            r_len       <= s_ip_length[w_idx*LEN_W +: LEN_W];
            r_ttl       <= s_ip_ttl[w_idx*TTL_W +: TTL_W];
            r_proto     <= s_ip_protocol[w_idx*PROTO_W +: PROTO_W];
            r_sip       <= s_ip_source_ip[w_idx*IP_W +: IP_W];
            r_dip       <= s_ip_dest_ip[w_idx*IP_W +: IP_W];
         end else if ((r_state == ST_HDR) && m_ip_hdr_ready) begin
            r_hdr_valid <= 1'b0;
         end
         if (w_pkt_end) r_ptr <= w_ptr_nxt;
      end
   end

   assign m_ip_hdr_valid          = r_hdr_valid;
   assign m_ip_dscp               = r_dscp;
   assign m_ip_ecn                = r_ecn;
   assign m_ip_length             = r_len;
   assign m_ip_ttl                = r_ttl;
   assign m_ip_protocol           = r_proto;
   assign m_ip_source_ip          = r_sip;
   assign m_ip_dest_ip            = r_dip;
   assign m_ip_payload_axis_tdata = s_ip_payload_axis_tdata[r_grant*8 +: 8];
   assign m_ip_payload_axis_tlast = s_ip_payload_axis_tlast[r_grant];
   assign m_ip_payload_axis_tuser = s_ip_payload_axis_tuser[r_grant];
   assign grant                   = r_grant;
   assign grant_valid             = (r_state != ST_IDLE);
   assign busy                    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter with four requesters; each requester's
// payload source emits bytes {id[1:0], beat[5:0]}.
module tb_ip_tx_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   hv = '0, hr;
   logic [N*6-1:0] dscp = '0;
   logic [N*2-1:0] ecn = '0;
   logic [N*16-1:0] len = '0;
   logic [N*8-1:0] ttl = '0, proto = '0;
   logic [N*32-1:0] sip = '0, dip = '0;
   logic [N*8-1:0] ptd;
   logic [N-1:0]   ptv, ptl, ptu, pto;
   logic           m_hv, m_hr = 1'b1;
   logic [5:0]     m_dscp;
   logic [1:0]     m_ecn;
   logic [15:0]    m_len;
   logic [7:0]     m_ttl, m_proto;
   logic [31:0]    m_sip, m_dip;
   logic [7:0]     m_td;
   logic           m_pv, m_pr = 1'b1, m_pl, m_pu;
   logic [1:0]     grant;
   logic           grant_valid, busy;

   int n_pass  = 0;
   int n_total = 0;
   int src_len[N];
   int beat_idx[N];
   logic [7:0] beat_q[$];
   int grant_q[$];
   int tlast_cnt;

   ip_tx_arbiter #(.S_COUNT(N)) dut (
      .clk(clk), .rst(rst),
      .s_ip_hdr_valid(hv), .s_ip_hdr_ready(hr),
      .s_ip_dscp(dscp), .s_ip_ecn(ecn), .s_ip_length(len), .s_ip_ttl(ttl),
      .s_ip_protocol(proto), .s_ip_source_ip(sip), .s_ip_dest_ip(dip),
      .s_ip_payload_axis_tdata(ptd), .s_ip_payload_axis_tvalid(ptv),
      .s_ip_payload_axis_tready(pto), .s_ip_payload_axis_tlast(ptl),
      .s_ip_payload_axis_tuser(ptu),
      .m_ip_hdr_valid(m_hv), .m_ip_hdr_ready(m_hr),
      .m_ip_dscp(m_dscp), .m_ip_ecn(m_ecn), .m_ip_length(m_len), .m_ip_ttl(m_ttl),
      .m_ip_protocol(m_proto), .m_ip_source_ip(m_sip), .m_ip_dest_ip(m_dip),
      .m_ip_payload_axis_tdata(m_td), .m_ip_payload_axis_tvalid(m_pv),
      .m_ip_payload_axis_tready(m_pr), .m_ip_payload_axis_tlast(m_pl),
      .m_ip_payload_axis_tuser(m_pu),
      .grant(grant), .grant_valid(grant_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      ptd = '0;
      ptv = '0;
      ptl = '0;
      ptu = '0;
      for (int i = 0; i < N; i++) begin
         ptd[i*8 +: 8] = {i[1:0], beat_idx[i][5:0]};
         ptv[i]        = (src_len[i] != 0);
         ptl[i]        = (beat_idx[i] == src_len[i] - 1);
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst) beat_idx[i] <= 0;
         else if (ptv[i] && pto[i]) beat_idx[i] <= ptl[i] ? 0 : beat_idx[i] + 1;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         tlast_cnt = 0;
         beat_q.delete();
         grant_q.delete();
      end else begin
         if (m_pv && m_pr) begin
            beat_q.push_back(m_td);
            if (m_pl) tlast_cnt++;
         end
         if (m_hv && m_hr) grant_q.push_back(int'(grant));
      end
   end

   task automatic do_reset();
      rst  = 1'b1;
      hv   = '0;
      m_hr = 1'b1;
      m_pr = 1'b1;
      for (int i = 0; i < N; i++) src_len[i] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_hdr(input int r, input logic [31:0] d, input logic [15:0] l);
      dscp[r*6 +: 6]   = 6'(r + 1);
      ecn[r*2 +: 2]    = 2'(r);
      len[r*16 +: 16]  = l;
      ttl[r*8 +: 8]    = 8'd64;
      proto[r*8 +: 8]  = 8'd17;
      sip[r*32 +: 32]  = 32'h0A00_0000 + 32'(r);
      dip[r*32 +: 32]  = d;
   endtask

   task automatic wait_hs(input int r, input bit drop, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         #1;
         if (hr[r] === 1'b1) begin
            ok = 1'b1;
            @(posedge clk);
            #1;
            if (drop) hv[r] = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic wait_tlast(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
         @(negedge clk);
         if (tlast_cnt >= n) ok = 1'b1;
      end
   endtask

   task automatic wait_grants(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
         @(negedge clk);
         if (grant_q.size() >= n) ok = 1'b1;
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
         @(negedge clk);
         #1;
         if (busy === 1'b0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++; if (m_hv !== 1'b0) $display("FAIL reset_hdr_valid got=%b want=0", m_hv); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
      n_total++; if (grant_valid !== 1'b0) $display("FAIL reset_grant_valid got=%b want=0", grant_valid); else n_pass++;
      n_total++; if (grant !== 2'd0) $display("FAIL reset_grant got=%0d want=0", grant); else n_pass++;
      n_total++; if (m_dip !== 32'h0) $display("FAIL reset_dest_ip got=%h want=0", m_dip); else n_pass++;
      n_total++; if (m_len !== 16'h0) $display("FAIL reset_length got=%h want=0", m_len); else n_pass++;
      n_total++; if (m_pv !== 1'b0) $display("FAIL reset_tvalid got=%b want=0", m_pv); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_single();
      bit ok;
      logic [7:0] exp_b;
      do_reset();
      load_hdr(0, 32'hC0A8_010A, 16'd28);
      load_hdr(1, 32'hC0A8_0114, 16'd30);
      src_len[0] = 4;
      m_hr = 1'b0;
      hv[0] = 1'b1;
      #1;
      n_total++; if (hr !== 4'b0001) $display("FAIL single_hdr_ready got=%b want=0001", hr); else n_pass++;
      wait_hs(0, 1'b1, ok);
      n_total++; if (ok !== 1'b1) $display("FAIL single_handshake_timeout got=%b want=1", ok); else n_pass++;
      n_total++; if (m_hv !== 1'b1) $display("FAIL single_hdr_valid_latency got=%b want=1", m_hv); else n_pass++;
      n_total++; if (m_dip !== 32'hC0A8_010A) $display("FAIL single_dest_ip got=%h want=c0a8010a", m_dip); else n_pass++;
      n_total++; if (m_len !== 16'd28) $display("FAIL single_length got=%0d want=28", m_len); else n_pass++;
      n_total++; if (m_dscp !== 6'd1 || m_ttl !== 8'd64 || m_proto !== 8'd17)
         $display("FAIL single_fields got=%0d/%0d/%0d want=1/64/17", m_dscp, m_ttl, m_proto); else n_pass++;
      n_total++; if (m_sip !== 32'h0A00_0000) $display("FAIL single_source_ip got=%h want=0a000000", m_sip); else n_pass++;
      n_total++; if (busy !== 1'b1 || grant !== 2'd0) $display("FAIL single_owner got=busy%b/g%0d want=busy1/g0", busy, grant); else n_pass++;
      m_hr = 1'b1;
      wait_tlast(1, ok);
      #1;
      n_total++; if (ok !== 1'b1) $display("FAIL single_tlast_timeout got=%b want=1", ok); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL single_busy_after_tlast got=%b want=0", busy); else n_pass++;
      n_total++; if (beat_q.size() !== 4) $display("FAIL single_beat_count got=%0d want=4", beat_q.size()); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         exp_b = 8'(k);
         n_total++; if (beat_q[k] !== exp_b) $display("FAIL single_beat%0d got=%h want=%h", k, beat_q[k], exp_b); else n_pass++;
      end
      // Pointer should now sit at 1, so requester 1 beats requester 0.
      src_len[1] = 2;
      hv = 4'b0011;
      #1;
      n_total++; if (hr !== 4'b0010) $display("FAIL single_pointer_advance got=%b want=0010", hr); else n_pass++;
      wait_hs(1, 1'b1, ok);
      hv[0] = 1'b0;
      wait_idle(ok);
   endtask

   task automatic test_simultaneous();
      bit ok;
      do_reset();
      load_hdr(0, 32'hC0A8_0001, 16'd22);
      load_hdr(1, 32'hC0A8_0002, 16'd23);
      src_len[0] = 2;
      src_len[1] = 3;
      hv = 4'b0011;
      #1;
      n_total++; if (hr !== 4'b0001) $display("FAIL simul_first_winner got=%b want=0001", hr); else n_pass++;
      wait_grants(4, ok);
      hv = '0;
      n_total++; if (ok !== 1'b1) $display("FAIL simul_grant_timeout got=%b want=1", ok); else n_pass++;
      wait_idle(ok);
      for (int k = 0; k < 4; k++) begin
         n_total++; if (grant_q[k] !== (k % 2)) $display("FAIL simul_grant%0d got=%0d want=%0d", k, grant_q[k], k % 2); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [7:0] exp_b;
      do_reset();
      load_hdr(0, 32'hC0A8_0001, 16'd22);
      load_hdr(1, 32'h0A0B_0C0D, 16'd100);
      src_len[0] = 2;
      src_len[1] = 4;
      m_hr = 1'b0;
      m_pr = 1'b0;
      hv[1] = 1'b1;
      wait_hs(1, 1'b1, ok);
      n_total++; if (ok !== 1'b1) $display("FAIL bp_handshake_timeout got=%b want=1", ok); else n_pass++;
      hv[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         n_total++; if (m_hv !== 1'b1) $display("FAIL bp_hdr_valid_c%0d got=%b want=1", c, m_hv); else n_pass++;
         n_total++; if (m_dip !== 32'h0A0B_0C0D || m_len !== 16'd100)
            $display("FAIL bp_hdr_stable_c%0d got=%h/%0d want=0a0b0c0d/100", c, m_dip, m_len); else n_pass++;
         n_total++; if (pto !== 4'b0000) $display("FAIL bp_tready_in_hdr_c%0d got=%b want=0000", c, pto); else n_pass++;
         n_total++; if (hr !== 4'b0000) $display("FAIL bp_nonowner_hdr_ready_c%0d got=%b want=0000", c, hr); else n_pass++;
      end
      m_hr = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 20 && tlast_cnt < 1; c++) begin
         @(negedge clk);
         m_pr = (c % 2 == 0);
         #1;
         n_total++; if (pto[0] !== 1'b0) $display("FAIL bp_nonowner_tready_c%0d got=%b want=0", c, pto[0]); else n_pass++;
         n_total++; if (pto[1] !== m_pr) $display("FAIL bp_owner_tready_c%0d got=%b want=%b", c, pto[1], m_pr); else n_pass++;
      end
      m_pr = 1'b1;
      n_total++; if (tlast_cnt !== 1) $display("FAIL bp_tlast_count got=%0d want=1", tlast_cnt); else n_pass++;
      n_total++; if (beat_q.size() !== 4) $display("FAIL bp_beat_count got=%0d want=4", beat_q.size()); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         exp_b = 8'h40 + 8'(k);
         n_total++; if (beat_q[k] !== exp_b) $display("FAIL bp_beat%0d got=%h want=%h", k, beat_q[k], exp_b); else n_pass++;
      end
      wait_hs(0, 1'b1, ok);
      wait_tlast(2, ok);
      n_total++; if (beat_q[4] !== 8'h00 || beat_q[5] !== 8'h01)
         $display("FAIL bp_waiter_payload got=%h,%h want=00,01", beat_q[4], beat_q[5]); else n_pass++;
      wait_idle(ok);
   endtask

   task automatic test_single_byte();
      bit ok;
      do_reset();
      load_hdr(0, 32'hC0A8_0001, 16'd22);
      load_hdr(1, 32'hC0A8_0002, 16'd21);
      src_len[0] = 2;
      src_len[1] = 1;
      hv[1] = 1'b1;
      wait_hs(1, 1'b1, ok);
      hv[0] = 1'b1;
      n_total++; if (hr !== 4'b0000) $display("FAIL sb_hdr_ready_while_owned got=%b want=0000", hr); else n_pass++;
      wait_tlast(1, ok);
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL sb_idle_after_one_beat got=%b want=0", busy); else n_pass++;
      n_total++; if (hr !== 4'b0001) $display("FAIL sb_next_winner got=%b want=0001", hr); else n_pass++;
      @(posedge clk);
      #1;
      hv[0] = 1'b0;
      n_total++; if (grant !== 2'd0 || m_hv !== 1'b1 || busy !== 1'b1)
         $display("FAIL sb_regrant got=g%0d/v%b/b%b want=g0/v1/b1", grant, m_hv, busy); else n_pass++;
      wait_tlast(2, ok);
      n_total++; if (tlast_cnt !== 2) $display("FAIL sb_tlast_count got=%0d want=2", tlast_cnt); else n_pass++;
      n_total++; if (beat_q[0] !== 8'h40 || beat_q[1] !== 8'h00)
         $display("FAIL sb_payload got=%h,%h want=40,00", beat_q[0], beat_q[1]); else n_pass++;
      wait_idle(ok);
   endtask

   task automatic test_reset_mid_packet();
      bit ok;
      do_reset();
      load_hdr(2, 32'hC0A8_0003, 16'd40);
      src_len[2] = 8;
      hv[2] = 1'b1;
      wait_hs(2, 1'b1, ok);
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (beat_q.size() >= 2) ok = 1'b1;
      end
      #1;
      n_total++; if (ok !== 1'b1 || grant !== 2'd2) $display("FAIL rm_in_payload got=ok%b/g%0d want=ok1/g2", ok, grant); else n_pass++;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_total++; if (m_hv !== 1'b0 || busy !== 1'b0 || grant_valid !== 1'b0)
         $display("FAIL rm_flags got=v%b/b%b/gv%b want=0/0/0", m_hv, busy, grant_valid); else n_pass++;
      n_total++; if (grant !== 2'd0) $display("FAIL rm_grant got=%0d want=0", grant); else n_pass++;
      n_total++; if (hr !== 4'b0000 || pto !== 4'b0000) $display("FAIL rm_readys got=%b/%b want=0000/0000", hr, pto); else n_pass++;
      n_total++; if (m_pv !== 1'b0) $display("FAIL rm_tvalid got=%b want=0", m_pv); else n_pass++;
      src_len[2] = 0;
      rst = 1'b0;
   endtask

   task automatic test_wrap();
      bit ok;
      do_reset();
      load_hdr(2, 32'hC0A8_0003, 16'd21);
      load_hdr(3, 32'hC0A8_0004, 16'd22);
      src_len[2] = 1;
      src_len[3] = 2;
      hv[2] = 1'b1;
      wait_hs(2, 1'b1, ok);
      wait_idle(ok);
      hv = 4'b1100;
      #1;
      n_total++; if (hr !== 4'b1000) $display("FAIL wrap_ptr3_winner got=%b want=1000", hr); else n_pass++;
      wait_grants(3, ok);
      hv = '0;
      n_total++; if (ok !== 1'b1) $display("FAIL wrap_grant_timeout got=%b want=1", ok); else n_pass++;
      wait_idle(ok);
      n_total++; if (grant_q[0] !== 2 || grant_q[1] !== 3 || grant_q[2] !== 2)
         $display("FAIL wrap_order got=%0d,%0d,%0d want=2,3,2", grant_q[0], grant_q[1], grant_q[2]); else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < N; i++) src_len[i] = 0;
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_single_byte();
      test_reset_mid_packet();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
